// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT_CYC  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants won while a fetch was waiting; raises
// o_at_limit once the fetch side is owed the next tie.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == CNT_W'(LIMIT));
  assign o_at_limit = w_at_limit;

  // NOTE: sequential state is updated with <= only, so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, with
// starvation protection for fetch and a per-access timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              err_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_valid;
  logic              r_dm_valid;
  logic              r_err;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_done;
  logic w_timeout;

  // A port in its completion cycle still shows its old request; mask it.
  assign w_if_elig = if_req_i & ~r_if_valid;
  assign w_dm_elig = dm_req_i & ~r_dm_valid;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk_i),
    .rst_n      (rst_n),
    .i_inc      (w_grant_dm & if_req_i),
    .i_clr      (w_grant_if),
    .o_at_limit (w_starved)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_dm  = 1'b0;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_dm_elig && !(w_if_elig && w_starved)) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = BUSY_DM;
        end else if (w_if_elig) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        w_timeout = !mem_ready_i && (r_tmo_cnt == TMO_LAST);
        w_done    = mem_ready_i || w_timeout;
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_grant_if) begin
        r_mem_addr <= if_addr_i;
        r_mem_we   <= 1'b0;
        r_tmo_cnt  <= '0;
      end
      if (w_grant_dm) begin
        r_mem_addr  <= dm_addr_i;
        r_mem_we    <= dm_we_i;
        r_mem_wdata <= dm_wdata_i;
        r_tmo_cnt   <= '0;
      end
      if (r_state != IDLE && !w_done) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_done) begin
        if (r_state == BUSY_IF) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= w_timeout ? '0 : mem_rdata_i;
        end else begin
          r_dm_valid <= 1'b1;
          // A completed write leaves the last load result visible.
          if (w_timeout)     r_dm_rdata <= '0;
          else if (!r_mem_we) r_dm_rdata <= mem_rdata_i;
        end
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign mem_req_o   = (r_state != IDLE);
  assign mem_we_o    = (r_state == BUSY_DM) & r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign if_rdata_o  = r_if_rdata;
  assign if_valid_o  = r_if_valid;
  assign dm_rdata_o  = r_dm_rdata;
  assign dm_valid_o  = r_dm_valid;
  assign err_o       = r_err;
  assign if_stall_o  = if_req_i & ~r_if_valid;
  assign dm_stall_o  = dm_req_i & ~r_dm_valid;

endmodule
